// File: rtl/dmem_responder.sv
// Wait-stated data memory for the MIPS memory stage, holding the pipeline via stall while an access is in flight.
// Optional feature macro: DMEM_BYTE_EN adds the per-lane byte-enable port `be`.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
`ifdef DMEM_BYTE_EN
  input  logic [3:0]  be,
`endif
  output logic [31:0] rdata,
  output logic        stall,
  output logic        addr_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
  logic                  stall_s, accept_s, req_s;
  logic                  op_wr_r, op_rd_r;
  logic [ADDR_WIDTH+1:0] addr_r;
  logic [31:0]           wdata_r;
  logic [31:0]           rdata_r;
  logic                  addr_err_r;
  logic                  misalign_s, ram_we_s;
  logic [3:0]            wmask_s;
  logic [ADDR_WIDTH-1:0] widx_s;
  logic                  unused_addr_hi_s;
  logic [31:0]           mem_r [DEPTH];
`ifdef DMEM_BYTE_EN
  logic [3:0]            be_r;
`endif

  assign req_s            = memRead | memWrite;
  assign widx_s           = addr_r[ADDR_WIDTH+1:2];
  // Upper address bits alias onto the RAM and are intentionally ignored.
  assign unused_addr_hi_s = ^addr[31:ADDR_WIDTH+2];

  // Access qualifiers for the latched request: lane mask, misalignment, RAM write strobe.
  always_comb begin
    wmask_s    = 4'b1111;
    misalign_s = 1'b0;
    ram_we_s   = 1'b0;
`ifdef DMEM_BYTE_EN
    wmask_s    = be_r;
    misalign_s = (be_r == 4'b1111) && (addr_r[1:0] != 2'b00);
`else
    misalign_s = (addr_r[1:0] != 2'b00);
`endif
    if ((state_r == RESP) && op_wr_r && !misalign_s) begin
      ram_we_s = 1'b1;
    end else begin
      ram_we_s = 1'b0;
    end
  end

  // Next-state, wait counter and stall decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    stall_s     = 1'b0;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          stall_s   = 1'b1;
          accept_s  = 1'b1;
          cnt_nxt_s = CNT_LOAD;
          if (WAIT_CYCLES == 32'sd0) begin
            state_nxt_s = RESP;
          end else begin
            state_nxt_s = WAIT;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        stall_s   = 1'b1;
        cnt_nxt_s = cnt_r - CNT_ONE;
        if (cnt_r <= CNT_ONE) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RESP: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Reset gates stall so it falls immediately even if the core keeps a request asserted.
  assign stall    = stall_s & rst;
  assign rdata    = rdata_r;
  assign addr_err = addr_err_r;

  // FSM state, request capture and registered responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      op_wr_r    <= 1'b0;
      op_rd_r    <= 1'b0;
      addr_r     <= {(ADDR_WIDTH+2){1'b0}};
      wdata_r    <= 32'h0000_0000;
      rdata_r    <= 32'h0000_0000;
      addr_err_r <= 1'b0;
`ifdef DMEM_BYTE_EN
      be_r       <= 4'b0000;
`endif
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      addr_err_r <= (state_r == RESP) && misalign_s;
      if (accept_s) begin
        op_wr_r <= memWrite;
        op_rd_r <= memRead & ~memWrite;
        addr_r  <= addr[ADDR_WIDTH+1:0];
        wdata_r <= wdata;
`ifdef DMEM_BYTE_EN
        be_r    <= be;
`endif
      end
      if ((state_r == RESP) && op_rd_r) begin
        rdata_r <= misalign_s ? 32'h0000_0000 : mem_r[widx_s];
      end
    end
  end

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_s[i]) begin
          mem_r[widx_s][8*i +: 8] <= wdata_r[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving the MIPS core's memory-stage data port: accepts the core's read/write requests (address, write data, memRead, memWriteM), holds them in an internal word-addressed RAM, and returns read data after a configurable number of wait states. While a request is outstanding it drives `stall` so the pipeline freezes the memory stage. It sits beside the instruction memory at the top level and replaces the zero-latency data RAM.

## Interface
- `ADDR_WIDTH`, 10: word-address width; RAM holds 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, 2: extra stall cycles per access, integer >= 0.

- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `memRead`  in  1  read request from the memory stage.
- `memWrite`  in  1  write request from the memory stage (core's `memWriteM`).
- `addr`  in  32  byte address (core's `ALUOutM`).
- `wdata`  in  32  write data (core's `writeDataM`).
- `be`  in  4  byte enables, bit i = byte lane i; present only with `DMEM_BYTE_EN`.
- `rdata`  out  32  read data, registered (core's `readDataM`).
- `stall`  out  1  request accepted and not yet complete; core holds all request inputs stable while high.
- `addr_err`  out  1  one-cycle pulse: completed access was misaligned.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if `memRead | memWrite`, latch op, `addr`, `wdata` (and `be`); `stall` = 1 combinationally this cycle; load counter with WAIT_CYCLES; go WAIT (or RESP directly when WAIT_CYCLES = 0). No request: stay IDLE, `stall` = 0.
- WAIT: `stall` = 1; decrement counter; on counter reaching 0 go RESP.
- RESP: `stall` = 0; read: `rdata` <= RAM[addr[ADDR_WIDTH+1:2]] at this cycle's edge; write: RAM updated at this cycle's edge; always return to IDLE. A request present in the following IDLE cycle is a new request.
- Both `memRead` and `memWrite` high: treated as a write; `rdata` unchanged.
- Misaligned (`addr[1:0]` != 0): no RAM write, `rdata` <= 0, `addr_err` = 1 for the RESP cycle's following cycle only.
- Address bits above ADDR_WIDTH+1 ignored (aliasing, no error).
- `rdata` holds its last value between reads; writes never modify `rdata`.
- Reset mid-access: FSM to IDLE immediately, pending write discarded. RAM contents are not reset; undefined after power-up.

## Timing
- Reset values: `stall` 0, `rdata` 0, `addr_err` 0, FSM IDLE, counter 0.
- Request first visible in cycle 0: `stall` high cycles 0..WAIT_CYCLES, low in cycle WAIT_CYCLES+1 (RESP).
- Read data valid on `rdata` from cycle WAIT_CYCLES+2 onward; write visible to a read accepted in cycle WAIT_CYCLES+2 or later.
- Access occupancy: WAIT_CYCLES+2 cycles; back-to-back requests accepted every WAIT_CYCLES+2 cycles.
- `stall` is the only combinational path from inputs (memRead/memWrite in IDLE); all other outputs registered.
- Inputs sampled only in IDLE; changes during WAIT/RESP ignored.

## Configuration
- `DMEM_BYTE_EN` defined: `be` port exists; write updates only lanes with `be[i]` = 1; `be` = 0 write is a legal no-op (still takes full latency). Misalignment check applies only when `be` is 4'b1111; sub-word writes use `addr[1:0]` freely.
- Undefined: no `be` port; every write is full word; misalignment check applies to all accesses.

## Test plan
- Reset release, WAIT_CYCLES=2, write 0xDEADBEEF to 0x10 then read 0x10 -> `stall` high 3 cycles each, `rdata` = 0xDEADBEEF in cycle 4 of read.
- WAIT_CYCLES=0, back-to-back reads of 0x0 and 0x4 after writes 0x11111111/0x22222222 -> `stall` alternates 1,0,1,0; `rdata` 0x11111111 then 0x22222222.
- Read 0x13 -> `addr_err` single pulse, `rdata` = 0; RAM at 0x10 unchanged on reread.
- Assert `rst` low during WAIT of a write to 0x20 -> `stall` drops asynchronously, later read of 0x20 returns prior contents.
- `memRead` and `memWrite` both high, address 0x8, data 0xA5A5A5A5 -> write performed, `rdata` unchanged; subsequent read returns 0xA5A5A5A5.
- With `DMEM_BYTE_EN`, word 0x0 = 0x00000000, write 0xFFFFFFFF with `be` = 4'b0101 -> read returns 0x00FF00FF.
